ssram_arb: RTL

Two-port arbiter and sequencer for the shared 32K x 32 synchronous SRAM buffer. Port 0 is the USB core endpoint-buffer path and port 1 is the host/register-bus path. The block grants one single-word access at a time and drives the SRAM strobes so read and write are never asserted together. It returns read data and a one-cycle acknowledge to the winning port. It sits between both requesters and the SRAM macro, and is the only driver of the SRAM address, data and strobe inputs.

---
 rtl/ssram_arb_if.sv | 40 ++++
 rtl/ssram_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ssram_arb_if.sv
// Requester and SRAM-side signal bundle for the two-port SRAM arbiter.
// slave is the arbiter's view, master is the view of the requesters and SRAM macro together.
interface ssram_arb_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 32
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_adr;
  logic [DW-1:0] p0_din;
  logic          p0_ack;
  logic [DW-1:0] p0_dout;
  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_adr;
  logic [DW-1:0] p1_din;
  logic          p1_ack;
  logic [DW-1:0] p1_dout;
  logic [AW-1:0] sram_adr_o;
  logic [DW-1:0] sram_dat_o;
  logic          sram_re_o;
  logic          sram_we_o;
  logic [DW-1:0] sram_dat_i;

  modport slave (
    input  p0_req, p0_we, p0_adr, p0_din,
    input  p1_req, p1_we, p1_adr, p1_din,
    input  sram_dat_i,
    output p0_ack, p0_dout, p1_ack, p1_dout,
    output sram_adr_o, sram_dat_o, sram_re_o, sram_we_o
  );

  modport master (
    output p0_req, p0_we, p0_adr, p0_din,
    output p1_req, p1_we, p1_adr, p1_din,
    output sram_dat_i,
    input  p0_ack, p0_dout, p1_ack, p1_dout,
    input  sram_adr_o, sram_dat_o, sram_re_o, sram_we_o
  );
endinterface

// File: rtl/ssram_arb.sv
// Two-port single-word arbiter/sequencer for the shared 32K x 32 synchronous SRAM.
// One access in flight at a time; all outputs registered.
module ssram_arb #(
  parameter int unsigned AW         = 15,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic        clk,
  input logic        rst_n,
  ssram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    ACK    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;       // port of current/last grant, 1 after reset
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          re_q, re_d;
  logic          wr_q, wr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] dout0_q, dout0_d;
  logic [DW-1:0] dout1_q, dout1_d;
  logic          any_req_s;
  logic          win_s;

  assign any_req_s = bus.p0_req | bus.p1_req;

  // Winner selection: lone requester wins; a tie goes to port 0 or to the port not granted last.
  always_comb begin
    if (bus.p0_req && bus.p1_req) begin
      if (FIXED_PRIO != 32'd0) begin
        win_s = 1'b0;
      end else begin
        win_s = ~gnt_q;
      end
    end else if (bus.p1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes/acks default low, data holds.
  always_comb begin
    gnt_d   = gnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    re_d    = 1'b0;
    wr_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          gnt_d = win_s;
          we_d  = win_s ? bus.p1_we  : bus.p0_we;
          adr_d = win_s ? bus.p1_adr : bus.p0_adr;
          dat_d = win_s ? bus.p1_din : bus.p0_din;
          re_d  = ~we_d;
          wr_d  = we_d;
        end else begin
          gnt_d = gnt_q;
        end
      end
      ACCESS: begin
        if (we_q) begin
          ack0_d = ~gnt_q;
          ack1_d = gnt_q;
        end else begin
          ack0_d = 1'b0;
        end
      end
      RDATA: begin
        ack0_d = ~gnt_q;
        ack1_d = gnt_q;
        if (gnt_q) begin
          dout1_d = bus.sram_dat_i;
        end else begin
          dout0_d = bus.sram_dat_i;
        end
      end
      ACK:     gnt_d = gnt_q;
      default: gnt_d = gnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= 1'b1;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      re_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      re_q    <= re_d;
      wr_q    <= wr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  assign bus.sram_adr_o = adr_q;
  assign bus.sram_dat_o = dat_q;
  assign bus.sram_re_o  = re_q;
  assign bus.sram_we_o  = wr_q;
  assign bus.p0_ack     = ack0_q;
  assign bus.p1_ack     = ack1_q;
  assign bus.p0_dout    = dout0_q;
  assign bus.p1_dout    = dout1_q;

endmodule
